block_collision_tracker: RTL and testbench
==========================================

Name: block_collision_tracker

Overview:
- Parametrised player-versus-obstacle tracker for the side-scrolling game. It has N obstacle slots and a configurable block size and player column.
- Accumulates scroll offset once per frame tick and tests every valid obstacle for horizontal overlap with the player square.
- Runs a grounded/rising/falling/crashed FSM with jump, auto-climb and stacked-support landing.
- Sits between the obstacle generator (packed positions) and the drawing FSM (player square position).

Parameters:
- NUM_BLOCKS, 5, number of obstacle slots.
- COORD_W, 11, coordinate and offset width; all position arithmetic is modulo 2^COORD_W.
- BLOCK_SIZE, 10, square/block edge in pixels; also the vertical step per tick.
- PLAYER_X, 59, fixed x of the player bottom-left corner; must be >= BLOCK_SIZE.
- GROUND_Y, 89, player bottom-left y when on the floor.
- CEIL_Y, 9, minimum allowed player y.
- JUMP_LEVELS, 3, BLOCK_SIZE steps risen per jump.
- AUTO_CLIMB, 1, 1 = a same-row hit while grounded steps the player up; 0 = the hit crashes.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- update_screen  input  1  frame tick; all state advances only on cycles where it is 1.
- scroll_step  input  COORD_W  pixels added to the offset per tick.
- block_x_pos  input  NUM_BLOCKS*COORD_W  packed obstacle x; slot i is at [i*COORD_W +: COORD_W].
- block_y_pos  input  NUM_BLOCKS*COORD_W  packed obstacle bottom-left y, same packing as block_x_pos.
- block_valid  input  NUM_BLOCKS  per-slot enable; invalid slots are ignored.
- jump_req  input  1  level, sampled only on ticks.
- square_x_pos  output  COORD_W  player x; constant PLAYER_X.
- square_y_pos  output  COORD_W  player bottom-left y, registered.
- scroll_offset  output  COORD_W  accumulated scroll, registered.
- grounded  output  1  1 while state is GROUNDED.
- collision  output  1  sticky; 1 while state is CRASHED.
- state  output  2  GROUNDED=0, RISING=1, FALLING=2, CRASHED=3.

Behaviour:
- Reset (reset=0 at a clock edge):
  - square_y_pos=GROUND_Y, scroll_offset=0, state=GROUNDED, rise counter=0, collision=0.
  - Reset has priority over update_screen.
- Cycles with update_screen=0: all registers hold.
- Per-slot relative x: rel_i = block_x_i - scroll_offset, mod 2^COORD_W, computed from the pre-tick offset.
- Overlap: ov_i = valid_i and PLAYER_X-(BLOCK_SIZE-1) <= rel_i <= PLAYER_X+(BLOCK_SIZE-1), unsigned compare.
- Hit (same row): hit = OR over i of (ov_i and block_y_i == square_y).
- Support (block directly beneath): sup = OR over i of (ov_i and block_y_i == square_y + BLOCK_SIZE); y==GROUND_Y also counts as support.
- All flags use pre-tick register values. Any number of slots may match at once; the reduction is a plain OR.
- Offset: every tick outside CRASHED, scroll_offset <= scroll_offset + scroll_step (wraps). It freezes in CRASHED.
- Priority each tick: hit > jump > gravity.
- GROUNDED:
  - hit and AUTO_CLIMB and y-BLOCK_SIZE >= CEIL_Y -> y -= BLOCK_SIZE, stay GROUNDED.
  - hit otherwise -> CRASHED.
  - Else jump_req -> RISING, y -= BLOCK_SIZE, rise counter = JUMP_LEVELS-1.
  - Else not sup -> FALLING, y unchanged.
  - Else hold.
- RISING:
  - hit -> CRASHED.
  - Else counter==0 or y-BLOCK_SIZE < CEIL_Y -> FALLING, y unchanged.
  - Else y -= BLOCK_SIZE, counter -= 1.
  - jump_req is ignored.
- FALLING:
  - hit -> CRASHED.
  - Else sup -> GROUNDED, y unchanged.
  - Else y += BLOCK_SIZE.
  - jump_req is ignored.
- CRASHED: all registers hold and collision=1; the only exit is reset.
- y only takes values GROUND_Y - k*BLOCK_SIZE, so the equality tests are exact.
- Latency: outputs reflect a tick on the cycle after the update_screen edge.

Test Plan:
- Reset: drive reset=0 for 1 cycle with update_screen=1 -> square_y_pos=89, scroll_offset=0, state=0, collision=0.
- Jump, no valid blocks, jump_req=1 on tick1 only:
  - y after ticks 1..3 = 79, 69, 59.
  - tick4 -> FALLING, y=59.
  - ticks 5..7 -> y = 69, 79, 89.
  - tick8 -> GROUNDED.
- Climb (AUTO_CLIMB=1), slot0 x=65 y=89 valid, scroll_step=0:
  - tick1 -> y=79, GROUNDED.
  - tick2 -> hold (support from slot0).
  - Then set scroll_step=20: once rel_0 < 50, next tick -> FALLING, following tick y=89, then GROUNDED.
- Crash (AUTO_CLIMB=0), same stimulus as the climb case:
  - tick1 -> state=3, collision=1.
  - Further ticks with jump_req=1 and scroll_step=10 -> y, offset and state unchanged.
  - reset=0 -> all cleared.
- Wrap: offset preloaded to 2040 via 204 ticks of scroll_step=10, slot2 x=55 y=89 valid -> rel=63, hit flagged on the next tick; slot4 invalid with the same coordinates contributes nothing.
- Multi-slot: slot1 same-row and slot3 support simultaneously while RISING -> CRASHED (hit priority).

Source files
------------

// File: rtl/block_collision_tracker.sv
// block_collision_tracker
//   Tracks a player square against NUM_BLOCKS scrolling obstacles. On every
//   frame tick it advances the scroll offset. It tests each valid obstacle for
//   horizontal overlap with the player column, then steps a
//   grounded/rising/falling/crashed state machine.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   GROUNDED (0) | standing on the floor or on a block; may jump or climb
//   RISING   (1) | moving up one BLOCK_SIZE per tick for the jump length
//   FALLING  (2) | moving down one BLOCK_SIZE per tick until supported
//   CRASHED  (3) | same-row contact; everything frozen until reset
//
// Ports
//   clock, reset (sync, active-low), update_screen (frame tick)
//   scroll_step   : offset increment per tick
//   block_x_pos / block_y_pos : packed per-slot coordinates, COORD_W each
//   block_valid   : per-slot enable
//   jump_req      : level, sampled on ticks
//   square_x_pos / square_y_pos : player bottom-left corner
//   scroll_offset : accumulated scroll
//   grounded, collision, state : state machine status
module block_collision_tracker #(
   parameter int NUM_BLOCKS  = 5,
   parameter int COORD_W     = 11,
   parameter int BLOCK_SIZE  = 10,
   parameter int PLAYER_X    = 59,
   parameter int GROUND_Y    = 89,
   parameter int CEIL_Y      = 9,
   parameter int JUMP_LEVELS = 3,
   parameter int AUTO_CLIMB  = 1
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           update_screen,
   input  logic [COORD_W-1:0]             scroll_step,
   input  logic [NUM_BLOCKS*COORD_W-1:0]  block_x_pos,
   input  logic [NUM_BLOCKS*COORD_W-1:0]  block_y_pos,
   input  logic [NUM_BLOCKS-1:0]          block_valid,
   input  logic                           jump_req,
   output logic [COORD_W-1:0]             square_x_pos,
   output logic [COORD_W-1:0]             square_y_pos,
   output logic [COORD_W-1:0]             scroll_offset,
   output logic                           grounded,
   output logic                           collision,
   output logic [1:0]                     state
);

   localparam int CNT_W = (JUMP_LEVELS > 2) ? $clog2(JUMP_LEVELS) : 1;

   localparam logic [COORD_W-1:0] OV_LO    = COORD_W'(PLAYER_X - (BLOCK_SIZE - 1));
   localparam logic [COORD_W-1:0] OV_HI    = COORD_W'(PLAYER_X + (BLOCK_SIZE - 1));
   localparam logic [COORD_W-1:0] STEP     = COORD_W'(BLOCK_SIZE);
   localparam logic [COORD_W-1:0] GROUND   = COORD_W'(GROUND_Y);
   // One extra bit so "y - BLOCK_SIZE >= CEIL_Y" cannot be fooled by underflow.
   localparam logic [COORD_W:0]   UP_MIN   = (COORD_W+1)'(CEIL_Y + BLOCK_SIZE);
   localparam logic [CNT_W-1:0]   CNT_INIT = CNT_W'(JUMP_LEVELS - 1);

   typedef enum logic [1:0] {
      GROUNDED = 2'd0,
      RISING   = 2'd1,
      FALLING  = 2'd2,
      CRASHED  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [COORD_W-1:0] y_q, y_d;
   logic [COORD_W-1:0] offset_q, offset_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [NUM_BLOCKS-1:0] hit_v, sup_v;
   logic                  hit, sup, can_rise;
   logic [COORD_W-1:0]    y_up, y_dn;

   // Relative x uses the pre-tick offset; subtraction wraps modulo 2^COORD_W.
   for (genvar g = 0; g < NUM_BLOCKS; g++) begin : g_slot
      logic [COORD_W-1:0] rel;
      logic [COORD_W-1:0] by;
      logic               ov;
      assign by       = block_y_pos[g*COORD_W +: COORD_W];
      assign rel      = block_x_pos[g*COORD_W +: COORD_W] - offset_q;
      assign ov       = block_valid[g] && (rel >= OV_LO) && (rel <= OV_HI);
      assign hit_v[g] = ov && (by == y_q);
      assign sup_v[g] = ov && (by == y_dn);
   end

   assign y_up     = y_q - STEP;
   assign y_dn     = y_q + STEP;
   assign hit      = |hit_v;
   assign sup      = (|sup_v) || (y_q == GROUND);
   assign can_rise = {1'b0, y_q} >= UP_MIN;

   always_comb begin
      state_d  = state_q;
      y_d      = y_q;
      cnt_d    = cnt_q;
      offset_d = offset_q;
      if (state_q != CRASHED) offset_d = offset_q + scroll_step;
      case (state_q)
         GROUNDED: begin
            if (hit) begin
               if (AUTO_CLIMB != 0 && can_rise) y_d = y_up;
               else                             state_d = CRASHED;
            end else if (jump_req) begin
               state_d = RISING;
               y_d     = y_up;
               cnt_d   = CNT_INIT;
            end else if (!sup) begin
               state_d = FALLING;
            end
         end
         RISING: begin
            if (hit) begin
               state_d = CRASHED;
            end else if (cnt_q == '0 || !can_rise) begin
               state_d = FALLING;
            end else begin
               y_d   = y_up;
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         FALLING: begin
            if (hit)      state_d = CRASHED;
            else if (sup) state_d = GROUNDED;
            else          y_d     = y_dn;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q  <= GROUNDED;
         y_q      <= GROUND;
         offset_q <= '0;
         cnt_q    <= '0;
      end else if (update_screen) begin
         state_q  <= state_d;
         y_q      <= y_d;
         offset_q <= offset_d;
         cnt_q    <= cnt_d;
      end
   end

   assign square_x_pos  = COORD_W'(PLAYER_X);
   assign square_y_pos  = y_q;
   assign scroll_offset = offset_q;
   assign state         = state_q;
   assign grounded      = (state_q == GROUNDED);
   assign collision     = (state_q == CRASHED);

endmodule

// File: tb/tb_block_collision_tracker.sv
// Bench for block_collision_tracker: two instances (auto-climb on / off)
// share all inputs; an integer-level game model is checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_block_collision_tracker;

   localparam int NB = 5;
   localparam int CW = 11;
   localparam int MODV = 2048;
   localparam int BS = 10;
   localparam int PX = 59;
   localparam int GY = 89;
   localparam int CY = 9;
   localparam int JL = 3;

   logic clock = 1'b0;
   logic reset, update_screen, jump_req;
   logic [CW-1:0]    scroll_step;
   logic [NB*CW-1:0] block_x_pos, block_y_pos;
   logic [NB-1:0]    block_valid;

   logic [CW-1:0] d_x [2];
   logic [CW-1:0] d_y [2];
   logic [CW-1:0] d_off [2];
   logic          d_gnd [2];
   logic          d_col [2];
   logic [1:0]    d_st [2];

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   // model state: phase 0=ground 1=rise 2=fall 3=crash
   int m_y [2];
   int m_off [2];
   int m_ph [2];
   int m_left [2];

   always #5 clock = ~clock;

   block_collision_tracker #(.AUTO_CLIMB(1)) u_climb (
      .clock(clock), .reset(reset), .update_screen(update_screen),
      .scroll_step(scroll_step), .block_x_pos(block_x_pos),
      .block_y_pos(block_y_pos), .block_valid(block_valid),
      .jump_req(jump_req), .square_x_pos(d_x[0]), .square_y_pos(d_y[0]),
      .scroll_offset(d_off[0]), .grounded(d_gnd[0]), .collision(d_col[0]),
      .state(d_st[0]));

   block_collision_tracker #(.AUTO_CLIMB(0)) u_crash (
      .clock(clock), .reset(reset), .update_screen(update_screen),
      .scroll_step(scroll_step), .block_x_pos(block_x_pos),
      .block_y_pos(block_y_pos), .block_valid(block_valid),
      .jump_req(jump_req), .square_x_pos(d_x[1]), .square_y_pos(d_y[1]),
      .scroll_offset(d_off[1]), .grounded(d_gnd[1]), .collision(d_col[1]),
      .state(d_st[1]));

   function automatic void check(string name, int act, int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endfunction

   task automatic model_tick(int k, bit climb);
      bit hit, sup;
      int rel, bx, by, above;
      hit = 1'b0;
      sup = (m_y[k] == GY);
      above = (m_y[k] + BS) % MODV;
      for (int i = 0; i < NB; i++) begin
         bx  = int'(block_x_pos[i*CW +: CW]);
         by  = int'(block_y_pos[i*CW +: CW]);
         rel = (bx - m_off[k] + MODV) % MODV;
         if (block_valid[i] && rel >= PX - BS + 1 && rel <= PX + BS - 1) begin
            if (by == m_y[k]) hit = 1'b1;
            if (by == above)  sup = 1'b1;
         end
      end
      if (m_ph[k] == 3) return;
      m_off[k] = (m_off[k] + int'(scroll_step)) % MODV;
      if (hit) begin
         if (m_ph[k] == 0 && climb && m_y[k] - BS >= CY) m_y[k] -= BS;
         else m_ph[k] = 3;
      end else if (m_ph[k] == 0) begin
         if (jump_req) begin
            m_ph[k] = 1; m_y[k] -= BS; m_left[k] = JL - 1;
         end else if (!sup) m_ph[k] = 2;
      end else if (m_ph[k] == 1) begin
         if (m_left[k] == 0 || m_y[k] - BS < CY) m_ph[k] = 2;
         else begin m_y[k] -= BS; m_left[k]--; end
      end else begin
         if (sup) m_ph[k] = 0;
         else m_y[k] += BS;
      end
   endtask

   always @(posedge clock) begin
      for (int k = 0; k < 2; k++) begin
         if (!reset) begin
            m_y[k] = GY; m_off[k] = 0; m_ph[k] = 0; m_left[k] = 0;
         end else if (update_screen) begin
            model_tick(k, k == 0);
         end
      end
   end

   always @(negedge clock) begin
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            check($sformatf("dut%0d square_x", k), int'(d_x[k]), PX);
            check($sformatf("dut%0d square_y", k), int'(d_y[k]), m_y[k]);
            check($sformatf("dut%0d offset", k), int'(d_off[k]), m_off[k]);
            check($sformatf("dut%0d state", k), int'(d_st[k]), m_ph[k]);
            check($sformatf("dut%0d grounded", k), int'(d_gnd[k]), int'(m_ph[k] == 0));
            check($sformatf("dut%0d collision", k), int'(d_col[k]), int'(m_ph[k] == 3));
         end
      end
   end

   task automatic tick(int n);
      update_screen = 1'b1;
      repeat (n) @(negedge clock);
      update_screen = 1'b0;
   endtask

   task automatic idle(int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic set_slot(int i, int x, int y, bit v);
      logic [CW-1:0] xv, yv;
      xv = CW'(x);
      yv = CW'(y);
      block_x_pos[i*CW +: CW] = xv;
      block_y_pos[i*CW +: CW] = yv;
      block_valid[i] = v;
   endtask

   task automatic do_reset();
      block_x_pos = '0; block_y_pos = '0; block_valid = '0;
      jump_req = 1'b0; scroll_step = '0;
      reset = 1'b0; update_screen = 1'b1;
      @(negedge clock);
      reset = 1'b1; update_screen = 1'b0;
   endtask

   initial begin
      int exp_y [8];
      int exp_st [8];
      exp_y  = '{79, 69, 59, 59, 69, 79, 89, 89};
      exp_st = '{1, 1, 1, 2, 2, 2, 2, 0};

      reset = 1'b0; update_screen = 1'b1; jump_req = 1'b0; scroll_step = '0;
      block_x_pos = '0; block_y_pos = '0; block_valid = '0;
      @(negedge clock);
      chk_en = 1'b1;
      check("reset y", int'(d_y[0]), 89);
      check("reset offset", int'(d_off[0]), 0);
      check("reset state", int'(d_st[0]), 0);
      check("reset collision", int'(d_col[0]), 0);
      reset = 1'b1; update_screen = 1'b0;
      idle(2);

      // jump with no valid blocks
      scroll_step = 3;
      for (int t = 0; t < 8; t++) begin
         jump_req = (t == 0);
         tick(1);
         check($sformatf("jump y t%0d", t + 1), int'(d_y[0]), exp_y[t]);
         check($sformatf("jump state t%0d", t + 1), int'(d_st[0]), exp_st[t]);
         if (t == 1) begin
            idle(3);
            check("idle hold y", int'(d_y[0]), 69);
         end
      end
      jump_req = 1'b0;
      check("jump offset", int'(d_off[0]), 24);

      // climb vs crash on a same-row block
      do_reset();
      set_slot(0, 65, 89, 1'b1);
      tick(1);
      check("climb t1 y", int'(d_y[0]), 79);
      check("climb t1 state", int'(d_st[0]), 0);
      check("crash t1 state", int'(d_st[1]), 3);
      check("crash t1 collision", int'(d_col[1]), 1);
      tick(1);
      check("climb t2 y", int'(d_y[0]), 79);
      check("climb t2 state", int'(d_st[0]), 0);
      scroll_step = 20;
      tick(1);
      check("climb t3 state", int'(d_st[0]), 0);
      tick(1);
      check("climb t4 state", int'(d_st[0]), 2);
      check("climb t4 y", int'(d_y[0]), 79);
      tick(1);
      check("climb t5 y", int'(d_y[0]), 89);
      tick(1);
      check("climb t6 state", int'(d_st[0]), 0);

      // crashed instance must stay frozen
      jump_req = 1'b1; scroll_step = 10;
      tick(3);
      jump_req = 1'b0;
      check("crash hold y", int'(d_y[1]), 89);
      check("crash hold offset", int'(d_off[1]), 0);
      check("crash hold state", int'(d_st[1]), 3);
      do_reset();
      check("crash reset state", int'(d_st[1]), 0);
      check("crash reset collision", int'(d_col[1]), 0);

      // offset wrap; invalid slot ignored, valid slot flagged
      scroll_step = 10;
      tick(204);
      check("wrap offset", int'(d_off[0]), 2040);
      scroll_step = 0;
      set_slot(4, 55, 89, 1'b0);
      tick(1);
      check("invalid slot y", int'(d_y[0]), 89);
      check("invalid slot state", int'(d_st[1]), 0);
      set_slot(2, 55, 89, 1'b1);
      scroll_step = 10;
      tick(1);
      check("wrap climb y", int'(d_y[0]), 79);
      check("wrap offset after", int'(d_off[0]), 2);
      check("wrap crash state", int'(d_st[1]), 3);

      // hit and support together while rising: hit wins
      do_reset();
      jump_req = 1'b1;
      tick(1);
      jump_req = 1'b0;
      check("multi rising", int'(d_st[0]), 1);
      set_slot(1, 59, 79, 1'b1);
      set_slot(3, 60, 89, 1'b1);
      tick(1);
      check("multi climb state", int'(d_st[0]), 3);
      check("multi crash state", int'(d_st[1]), 3);
      check("multi y", int'(d_y[0]), 79);
      idle(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
